// File: rtl/memops_arbiter_if.sv
// Bundle between the arbiter, its two requesters (A = CPU, B = debug/DMA) and the
// shared memory unit. slave = arbiter view, master = environment view.
interface memops_arbiter_if;
  logic        i_a_stb, i_b_stb;
  logic [2:0]  i_a_op, i_b_op;
  logic [31:0] i_a_addr, i_b_addr;
  logic [31:0] i_a_data, i_b_data;
  logic [4:0]  i_a_oreg, i_b_oreg;
  logic        o_a_stall, o_b_stall;
  logic        o_a_valid, o_b_valid, o_a_err, o_b_err;
  logic [4:0]  o_wreg;
  logic [31:0] o_result;
  logic        o_mem_stb;
  logic [2:0]  o_mem_op;
  logic [31:0] o_mem_addr, o_mem_data;
  logic [4:0]  o_mem_oreg;
  logic        i_mem_stalled, i_mem_busy, i_mem_rdbusy, i_mem_valid, i_mem_done, i_mem_err;
  logic [4:0]  i_mem_wreg;
  logic [31:0] i_mem_result;
  logic        o_owner, o_busy;

  modport slave (
    input  i_a_stb, i_b_stb, i_a_op, i_b_op, i_a_addr, i_b_addr, i_a_data, i_b_data,
           i_a_oreg, i_b_oreg,
           i_mem_stalled, i_mem_busy, i_mem_rdbusy, i_mem_valid, i_mem_done, i_mem_err,
           i_mem_wreg, i_mem_result,
    output o_a_stall, o_b_stall, o_a_valid, o_b_valid, o_a_err, o_b_err, o_wreg, o_result,
           o_mem_stb, o_mem_op, o_mem_addr, o_mem_data, o_mem_oreg, o_owner, o_busy
  );

  modport master (
    output i_a_stb, i_b_stb, i_a_op, i_b_op, i_a_addr, i_b_addr, i_a_data, i_b_data,
           i_a_oreg, i_b_oreg,
           i_mem_stalled, i_mem_busy, i_mem_rdbusy, i_mem_valid, i_mem_done, i_mem_err,
           i_mem_wreg, i_mem_result,
    input  o_a_stall, o_b_stall, o_a_valid, o_b_valid, o_a_err, o_b_err, o_wreg, o_result,
           o_mem_stb, o_mem_op, o_mem_addr, o_mem_data, o_mem_oreg, o_owner, o_busy
  );
endinterface

// File: rtl/memops_arbiter.sv
// Two-port owner arbiter in front of a ZipCPU memory unit; enforces depth, direction
// and error-flush issue rules. Define MEMARB_ROUNDROBIN_EN for round-robin tie-break.

// Per-port stall and response steering.
module memops_arbiter_port (
  input  logic stb,
  input  logic req_own,
  input  logic rsp_own,
  input  logic block,
  input  logic mem_valid,
  input  logic mem_err,
  output logic stall,
  output logic valid,
  output logic err
);
  assign stall = stb && (!req_own || block);
  assign valid = rsp_own && mem_valid;
  assign err   = rsp_own && mem_err;
endmodule

module memops_arbiter #(
  parameter int LGDEPTH      = 4,
  parameter int OPT_MAXDEPTH = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  memops_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, FLUSH} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  oreg;
  } mem_req_t;

  state_e                state_q, state_d;
  logic [LGDEPTH-1:0]    count_q, count_d;
  logic                  dir_q, dir_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;

  mem_req_t [NUM_PORTS-1:0] req;
  mem_req_t                 sel;
  logic [NUM_PORTS-1:0]     stb, req_own, rsp_own, stall, valid, err;
  logic                     owning, done_eff, full, block, mem_stb, grant;

  assign stb    = {bus.i_b_stb, bus.i_a_stb};
  assign req[0] = {bus.i_a_op, bus.i_a_addr, bus.i_a_data, bus.i_a_oreg};
  assign req[1] = {bus.i_b_op, bus.i_b_addr, bus.i_b_data, bus.i_b_oreg};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dir_d    = dir_q;
    last_d   = last_q;
    owner_d  = owner_q;
    sel      = req[owner_q];
    owning   = (state_q == OWN_A) || (state_q == OWN_B);
    // A done with nothing outstanding is a protocol error; drop it so count floors at 0.
    done_eff = bus.i_mem_done && (count_q != '0);
    // A retiring op frees its slot in the same cycle.
    full     = (count_q - LGDEPTH'(done_eff)) == LGDEPTH'(OPT_MAXDEPTH);
    block    = bus.i_mem_stalled || bus.i_mem_err || full ||
               ((count_q != '0) && (sel.op[0] != dir_q));
    mem_stb  = owning && stb[owner_q] && !block;
    req_own  = '0;
    rsp_own  = '0;
    if (owning)           req_own[owner_q] = 1'b1;
    if (state_q != IDLE)  rsp_own[owner_q] = 1'b1;
`ifdef MEMARB_ROUNDROBIN_EN
    grant    = (&stb) ? !last_q : stb[1];
`else
    grant    = stb[1] && !stb[0];
`endif

    case (state_q)
      IDLE: begin
        if (|stb) begin
          owner_d = grant;
          last_d  = grant;
          state_d = grant ? OWN_B : OWN_A;
        end
      end
      OWN_A, OWN_B: begin
        if (mem_stb && !done_eff)      count_d = count_q + 1'b1;
        else if (!mem_stb && done_eff) count_d = count_q - 1'b1;
        if (mem_stb) dir_d = sel.op[0];
        if (bus.i_mem_err) begin
          count_d = '0;
          state_d = FLUSH;
        end else if ((count_d == '0) && !bus.i_mem_busy && !mem_stb) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        count_d = '0;
        if (!bus.i_mem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    memops_arbiter_port u_port (
      .stb       (stb[i]),
      .req_own   (req_own[i]),
      .rsp_own   (rsp_own[i]),
      .block     (block),
      .mem_valid (bus.i_mem_valid),
      .mem_err   (bus.i_mem_err),
      .stall     (stall[i]),
      .valid     (valid[i]),
      .err       (err[i])
    );
  end

  assign bus.o_a_stall  = stall[0];
  assign bus.o_b_stall  = stall[1];
  assign bus.o_a_valid  = valid[0];
  assign bus.o_b_valid  = valid[1];
  assign bus.o_a_err    = err[0];
  assign bus.o_b_err    = err[1];
  // Response data is a straight pass-through, forced low while reset is held.
  assign bus.o_wreg     = i_reset_n ? bus.i_mem_wreg   : '0;
  assign bus.o_result   = i_reset_n ? bus.i_mem_result : '0;
  assign bus.o_mem_stb  = mem_stb;
  assign bus.o_mem_op   = owning ? sel.op   : '0;
  assign bus.o_mem_addr = owning ? sel.addr : '0;
  assign bus.o_mem_data = owning ? sel.data : '0;
  assign bus.o_mem_oreg = owning ? sel.oreg : '0;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_owner    = (state_q != IDLE) && owner_q;

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!(bus.i_mem_done  && (count_q == '0)));
      assert (!(bus.i_mem_valid && (count_q == '0)));
    end
  end
`endif
endmodule

// File: tb/tb_memops_arbiter.sv
// Randomized bench for memops_arbiter against a queue-based model of ownership and
// in-flight operations; a few directed sequences run first.
module tb_memops_arbiter;
  localparam int LGD  = 4;
  localparam int MAXD = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memops_arbiter_if bus ();

  memops_arbiter #(.LGDEPTH(LGD), .OPT_MAXDEPTH(MAXD)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = free, 1 = owned, 2 = flushing; infl holds the store-bit of each op in flight.
  int mode, ownid, lastg;
  bit infl[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.i_a_stb = 0; bus.i_b_stb = 0;
    bus.i_a_op = 3'b010; bus.i_b_op = 3'b010;
    bus.i_a_addr = 0; bus.i_b_addr = 0; bus.i_a_data = 0; bus.i_b_data = 0;
    bus.i_a_oreg = 0; bus.i_b_oreg = 0;
    bus.i_mem_stalled = 0; bus.i_mem_busy = 0; bus.i_mem_rdbusy = 0;
    bus.i_mem_valid = 0; bus.i_mem_done = 0; bus.i_mem_err = 0;
    bus.i_mem_wreg = 0; bus.i_mem_result = 0;
  endtask

  function automatic logic [2:0] rand_op();
    logic [2:0] op;
    op[2:1] = 2'(($urandom % 3) + 1);
    op[0]   = ($urandom % 4 == 0);
    return op;
  endfunction

  task automatic rand_inputs();
    int n;
    n = infl.size();
    bus.i_a_stb  = ($urandom % 3 != 0);
    bus.i_b_stb  = ($urandom % 3 == 0);
    bus.i_a_op   = rand_op();
    bus.i_b_op   = rand_op();
    bus.i_a_addr = $urandom; bus.i_b_addr = $urandom;
    bus.i_a_data = $urandom; bus.i_b_data = $urandom;
    bus.i_a_oreg = 5'($urandom); bus.i_b_oreg = 5'($urandom);
    bus.i_mem_stalled = ($urandom % 5 == 0);
    bus.i_mem_done    = (n > 0) ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
    bus.i_mem_valid   = bus.i_mem_done && ($urandom % 2 == 0);
    bus.i_mem_busy    = (n > 0) || ($urandom % 4 == 0);
    bus.i_mem_rdbusy  = bus.i_mem_busy && ($urandom % 2 == 0);
    bus.i_mem_err     = ($urandom % 50 == 0);
    bus.i_mem_wreg    = 5'($urandom);
    bus.i_mem_result  = $urandom;
  endtask

  // Called at a negedge with inputs already applied: check, advance the model, move to next negedge.
  task automatic tick();
    logic [1:0]  s;
    logic [2:0]  cop;
    logic [31:0] caddr, cdata;
    logic [4:0]  coreg;
    bit own, rsp, dn, blk, ostb;
    int n, pick;
    #1;
    s     = {bus.i_b_stb, bus.i_a_stb};
    own   = (mode == 1);
    rsp   = (mode != 0);
    cop   = ownid ? bus.i_b_op   : bus.i_a_op;
    caddr = ownid ? bus.i_b_addr : bus.i_a_addr;
    cdata = ownid ? bus.i_b_data : bus.i_a_data;
    coreg = ownid ? bus.i_b_oreg : bus.i_a_oreg;
    n     = infl.size();
    dn    = bus.i_mem_done && (n > 0);
    blk   = bus.i_mem_stalled || bus.i_mem_err || (n - int'(dn) == MAXD) ||
            (n > 0 && cop[0] != infl[0]);
    ostb  = own && s[ownid] && !blk;

    chk("mem_stb",  32'(bus.o_mem_stb),  32'(ostb));
    chk("a_stall",  32'(bus.o_a_stall),  32'(s[0] && !(own && ownid == 0 && !blk)));
    chk("b_stall",  32'(bus.o_b_stall),  32'(s[1] && !(own && ownid == 1 && !blk)));
    chk("mem_op",   32'(bus.o_mem_op),   own ? 32'(cop) : 32'd0);
    chk("mem_addr", bus.o_mem_addr,      own ? caddr : 32'd0);
    chk("mem_data", bus.o_mem_data,      own ? cdata : 32'd0);
    chk("mem_oreg", 32'(bus.o_mem_oreg), own ? 32'(coreg) : 32'd0);
    chk("a_valid",  32'(bus.o_a_valid),  32'(rsp && ownid == 0 && bus.i_mem_valid));
    chk("b_valid",  32'(bus.o_b_valid),  32'(rsp && ownid == 1 && bus.i_mem_valid));
    chk("a_err",    32'(bus.o_a_err),    32'(rsp && ownid == 0 && bus.i_mem_err));
    chk("b_err",    32'(bus.o_b_err),    32'(rsp && ownid == 1 && bus.i_mem_err));
    chk("wreg",     32'(bus.o_wreg),     32'(bus.i_mem_wreg));
    chk("result",   bus.o_result,        bus.i_mem_result);
    chk("busy",     32'(bus.o_busy),     32'(rsp));
    chk("owner",    32'(bus.o_owner),    32'(rsp && ownid == 1));

    if (mode == 0) begin
      if (s != 2'b00) begin
`ifdef MEMARB_ROUNDROBIN_EN
        pick = (s == 2'b11) ? (1 - lastg) : (s[1] ? 1 : 0);
`else
        pick = s[0] ? 0 : 1;
`endif
        ownid = pick;
        lastg = pick;
        mode  = 1;
      end
    end else if (mode == 1) begin
      if (ostb) infl.push_back(cop[0]);
      if (dn) void'(infl.pop_front());
      if (bus.i_mem_err) begin
        infl.delete();
        mode = 2;
      end else if (infl.size() == 0 && !bus.i_mem_busy && !ostb) begin
        mode = 0;
      end
    end else begin
      if (!bus.i_mem_busy) mode = 0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    mode = 0; ownid = 0; lastg = 1;
    infl.delete();
  endtask

  // Reset asserted between edges: outputs must fall immediately.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_stb", 32'(bus.o_mem_stb), 32'd0);
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    chk("rst_owner",   32'(bus.o_owner),   32'd0);
    chk("rst_a_stall", 32'(bus.o_a_stall), 32'(bus.i_a_stb));
    chk("rst_b_stall", 32'(bus.o_b_stall), 32'(bus.i_b_stb));
    chk("rst_a_valid", 32'(bus.o_a_valid), 32'd0);
    chk("rst_result",  bus.o_result,       32'd0);
    chk("rst_mem_op",  32'(bus.o_mem_op),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    bus.i_mem_result = 32'h1234_5678;
    reset_pulse();
    clear_inputs();

    // A load to 0x100, one response, release.
    tick();
    bus.i_a_stb = 1; bus.i_a_op = 3'b010; bus.i_a_addr = 32'h100;
    tick();
    #1 chk("grant_latency", 32'(bus.o_mem_stb), 32'd1);
    chk("grant_addr", bus.o_mem_addr, 32'h100);
    tick();
    bus.i_a_stb = 0; bus.i_mem_busy = 1;
    tick();
    bus.i_mem_valid = 1; bus.i_mem_done = 1; bus.i_mem_result = 32'hDEAD_BEEF; bus.i_mem_wreg = 5'd7;
    #1 chk("a_valid_beef", 32'(bus.o_a_valid), 32'd1);
    chk("result_beef", bus.o_result, 32'hDEAD_BEEF);
    tick();
    clear_inputs();
    tick();
    tick();
    #1 chk("released", 32'(bus.o_busy), 32'd0);

    // Simultaneous requests twice in a row.
    for (int r = 0; r < 2; r++) begin
      bus.i_a_stb = 1; bus.i_b_stb = 1;
      tick();
      bus.i_a_stb = 0; bus.i_b_stb = 0;
      #1;
`ifdef MEMARB_ROUNDROBIN_EN
      chk("tie_owner", 32'(bus.o_owner), 32'(r));
`else
      chk("tie_owner", 32'(bus.o_owner), 32'd0);
`endif
      tick();
      tick();
    end

    // Depth limit: three back-to-back loads with MAXD=2.
    bus.i_a_stb = 1; bus.i_a_op = 3'b010;
    tick();
    tick();
    tick();
    #1 chk("depth_stall", 32'(bus.o_a_stall), 32'd1);
    bus.i_mem_busy = 1; bus.i_mem_done = 1;
    #1 chk("depth_done_accept", 32'(bus.o_mem_stb), 32'd1);
    tick();
    bus.i_mem_done = 0;
    #1 chk("depth_still_full", 32'(bus.o_a_stall), 32'd1);
    bus.i_a_stb = 0;
    bus.i_mem_done = 1;
    tick();
    tick();
    clear_inputs();
    tick();
    tick();

    // Randomized run with occasional mid-transaction resets.
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      if (c % 700 == 350) reset_pulse();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
